// File: rtl/jsilicon_pkg.sv
// Shared types for the ALU/UART command sequencer: FSM states, opcodes and the
// command word carried through the FIFO.
package jsilicon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ALU,
        SEND_HI,
        WAIT_HI,
        SEND_LO,
        WAIT_LO,
        DONE
    } seq_state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/alu_cmd_sequencer_fifo.sv
// Command FIFO with a registered occupancy count; full/empty come straight
// from the count so cmd_ready never depends on a same-cycle pop.
module cmd_fifo
    import jsilicon_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [CMD_W-1:0] wdata,
    input  logic             pop,
    output logic [CMD_W-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CMD_W-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Pops one command at a time into the ALU, captures the result after a fixed
// latency and streams it to the UART as bytes, MSB first.
//
// state    | meaning
// IDLE     | waiting for a queued command with ena=1
// ISSUE    | operands on the ALU, latency timer loaded
// WAIT_ALU | timer counting down (paused while ena=0)
// SEND_HI  | wait for UART idle, launch high byte
// WAIT_HI  | high byte in flight
// SEND_LO  | wait for UART idle, launch low byte
// WAIT_LO  | low byte in flight
// DONE     | one-cycle res_done
module alu_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ALU_LAT    = 1,
    parameter int SEND_HI    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [2:0]  cmd_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    input  logic [15:0] alu_result,
    output logic [7:0]  uart_data,
    output logic        uart_start,
    input  logic        uart_busy,
    output logic [15:0] res_data,
    output logic        res_done,
    output logic        seq_busy
);
    import jsilicon_pkg::*;

    localparam logic [2:0] LAT_LOAD = 3'(ALU_LAT - 1);

    seq_state_t state;
    seq_state_t next_state;
    cmd_t       wr_cmd;
    cmd_t       head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       alu_tick;
    logic       lat_zero;
    logic [2:0] lat_cnt;

    assign wr_cmd    = '{a: cmd_a, b: cmd_b, op: cmd_op};
    assign cmd_ready = !fifo_full;
    assign seq_busy  = (state != IDLE);
    assign alu_tick  = (state == WAIT_ALU) && ena;
    assign lat_zero  = (lat_cnt == 3'd0);

    cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .wdata (wr_cmd),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // uart_start is high exactly in the first WAIT_* cycle, which is the cycle
    // the UART has not yet raised busy, so it doubles as the ignore window.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (ena && !fifo_empty) begin
                    pop        = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE:    next_state = WAIT_ALU;
            WAIT_ALU: begin
                if (alu_tick && lat_zero)
                    next_state = (SEND_HI != 0) ? jsilicon_pkg::SEND_HI : SEND_LO;
            end
            jsilicon_pkg::SEND_HI: if (!uart_busy) next_state = WAIT_HI;
            WAIT_HI:  if (!uart_start && !uart_busy) next_state = SEND_LO;
            SEND_LO:  if (!uart_busy) next_state = WAIT_LO;
            WAIT_LO:  if (!uart_start && !uart_busy) next_state = DONE;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            lat_cnt    <= '0;
            res_data   <= '0;
            uart_data  <= '0;
            uart_start <= 1'b0;
            res_done   <= 1'b0;
        end else begin
            uart_start <= 1'b0;
            res_done   <= (next_state == DONE);
            if (pop) begin
                alu_a  <= head.a;
                alu_b  <= head.b;
                alu_op <= head.op;
            end
            if (state == ISSUE)
                lat_cnt <= LAT_LOAD;
            else if (alu_tick && !lat_zero)
                lat_cnt <= lat_cnt - 3'd1;
            if (alu_tick && lat_zero)
                res_data <= alu_result;
            if (state == jsilicon_pkg::SEND_HI && !uart_busy) begin
                uart_data  <= res_data[15:8];
                uart_start <= 1'b1;
            end
            if (state == SEND_LO && !uart_busy) begin
                uart_data  <= res_data[7:0];
                uart_start <= 1'b1;
            end
        end
    end

endmodule
